iso7816_direction_sniffer: RTL
==============================

// Module: iso7816_direction_sniffer
// PURPOSE
//  Downstream consumer of the passive direction probe's termMon/cardMon wires.
//  Decides per character which side drove the start bit (first falling edge wins).
//  Deserialises the character (direct convention, LSB first, even parity) and emits
//  byte + direction + parity status. Used by the test bench as a transparent ISO7816 line monitor.
// PARAMETERS
//  ETU_W        16  width of clocksPerEtu and the internal ETU counter
//  SYNC_STAGES  2   flip-flop synchroniser depth on termMon/cardMon (>=2)
// PORTS
//  clk           in   1      single clock
//  nReset        in   1      asynchronous, active-low reset
//  enable        in   1      0: hold in IDLE, abort any character in progress
//  clocksPerEtu  in   ETU_W  clk cycles per ETU; values <4 behave as 4
//  termMon       in   1      line level seen at terminal side
//  cardMon       in   1      line level seen at card side
//  dataOut       out  8      received byte, valid with dataValid
//  dirOut        out  1      0 = terminal->card, 1 = card->terminal
//  dirAmbiguous  out  1      both monitors fell in the same clk (dirOut forced 0)
//  parityError   out  1      even-parity check failed
//  dataValid     out  1      one-clk pulse; dataOut/dir*/parityError stable until next pulse
//  busy          out  1      1 from start-edge detection until rearm
//  errSig        out  1      error-signal seen (only with ISO_SNIFF_ERRSIG_EN, else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, synchroniser flops preset to 1.
//  Both inputs are synchronised (SYNC_STAGES); all decisions use the synchronised termS/cardS.
//  States: IDLE -> START -> DATA -> PARITY -> GUARD -> IDLE.
//  IDLE: on the first clk with termS=0 or cardS=0 (both previously 1), latch direction:
//   termS=0 & cardS=1 -> dir=0; cardS=0 & termS=1 -> dir=1; both 0 -> dir=0, ambiguous=1.
//   Clear etuCnt and bitCnt, set busy, go to START. The sampled line is the originator's monitor.
//  etuCnt counts 0..clocksPerEtu-1 and wraps; sample point = etuCnt == clocksPerEtu>>1.
//  START: at the sample point, if line=1 -> false start: return to IDLE, clear busy, no dataValid.
//   Otherwise go to DATA.
//  DATA: 8 sample points, shifted in LSB first, bitCnt 0..7.
//  PARITY: 9th sample; parityError = ^{data,parityBit}.
//   Next clk: load outputs and pulse dataValid (latency = 9.5 ETU + 1 clk + sync delay).
//  GUARD: wait until termS=1 and cardS=1 for one full ETU, then IDLE and clear busy.
//   A low pulse during GUARD is never treated as a start bit.
//  enable=0 in any state: next clk IDLE, busy=0, no dataValid; previously latched outputs are kept.
//  clocksPerEtu is sampled at the start edge; later changes affect only the next character.
// CONFIGURATION
//  `ifdef ISO_SNIFF_ERRSIG_EN: dataValid is delayed to the sample at 10.5 ETU (one ETU after
//   parity). errSig = line==0 at that sample. All other outputs are loaded at the same clk.
//  Without the macro: dataValid timing is as above, errSig is constant 0, and that extra sample is not taken.
// STRUCTURE
//  Package iso7816_sniff_pkg: DIR_TERM=1'b0, DIR_CARD=1'b1, state enum, ETU_MIN=4.
//  Sub-module iso7816_sync_bit (SYNC_STAGES-deep synchroniser with preset-to-1 flops),
//   instantiated twice. Everything else, including the FSM, stays in this module.
// TESTING
//  1 clocksPerEtu=372; terminal sends 0x3B with termMon falling 3 clk before cardMon
//    -> one dataValid, dataOut=0x3B, dirOut=0, dirAmbiguous=0, parityError=0.
//  2 Card sends 0x55 with the parity bit inverted, cardMon leading
//    -> dataOut=0x55, dirOut=1, parityError=1.
//  3 A 100-clk low glitch on both lines (clocksPerEtu=372)
//    -> false start, no dataValid, busy back to 0 within 200 clk.
//  4 Both monitors fall in the same clk, byte 0xA5 -> dirAmbiguous=1, dirOut=0, dataOut=0xA5.
//  5 nReset asserted at bit 4 of a character -> outputs 0 immediately. Next full character
//    is received correctly. Also enable=0 mid-character -> no dataValid.
//  6 ISO_SNIFF_ERRSIG_EN: receiver holds the line low from 10.5 to 12 ETU
//    -> dataValid with errSig=1, no spurious character during GUARD.
//    Same stimulus without the macro -> errSig=0 and no extra dataValid.

Source files
------------

// File: rtl/iso7816_sniff_pkg.sv
// Shared constants and FSM state type for the ISO7816 direction sniffer.
package iso7816_sniff_pkg;
    localparam logic DIR_TERM = 1'b0;
    localparam logic DIR_CARD = 1'b1;
    localparam int   ETU_MIN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_GUARD
    } sniffState_t;
endpackage

// File: rtl/iso7816_sync_bit.sv
// Multi-stage synchroniser; flops preset to 1 so an idle (high) line never looks like a start bit.
module iso7816_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nReset,
    input  logic dataIn,
    output logic dataSync
);
    logic [STAGES-1:0] stages;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stages <= '1;
        end else begin
            stages <= {stages[STAGES-2:0], dataIn};
        end
    end

    assign dataSync = stages[STAGES-1];
endmodule

// File: rtl/iso7816_direction_sniffer.sv
// Passive ISO7816 line monitor: decides which side drove each start bit and deserialises the character.
// Optional ISO_SNIFF_ERRSIG_EN adds an error-signal sample one ETU after parity and delays dataValid to it.
module iso7816_direction_sniffer
    import iso7816_sniff_pkg::*;
#(
    parameter int ETU_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             enable,
    input  logic [ETU_W-1:0] clocksPerEtu,
    input  logic             termMon,
    input  logic             cardMon,
    output logic [7:0]       dataOut,
    output logic             dirOut,
    output logic             dirAmbiguous,
    output logic             parityError,
    output logic             dataValid,
    output logic             busy,
    output logic             errSig
);
    logic termS, cardS;
    logic termPrev, cardPrev;

    iso7816_sync_bit #(.STAGES(SYNC_STAGES)) uSyncTerm (
        .clk(clk), .nReset(nReset), .dataIn(termMon), .dataSync(termS)
    );
    iso7816_sync_bit #(.STAGES(SYNC_STAGES)) uSyncCard (
        .clk(clk), .nReset(nReset), .dataIn(cardMon), .dataSync(cardS)
    );

    sniffState_t      state;
    logic [ETU_W-1:0] etuCnt, etuLim, etuNext, clampedEtu;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             dirLat, ambLat;
    logic             line, sampleHit, etuWrap, startEdge;

    assign clampedEtu = (clocksPerEtu < ETU_W'(ETU_MIN)) ? ETU_W'(ETU_MIN) : clocksPerEtu;
    // Only the originator's monitor is sampled; the other side just echoes it with skew.
    assign line      = (dirLat == DIR_CARD) ? cardS : termS;
    assign sampleHit = (etuCnt == (etuLim >> 1));
    assign etuWrap   = (etuCnt == etuLim - ETU_W'(1));
    assign etuNext   = etuWrap ? '0 : etuCnt + ETU_W'(1);
    assign startEdge = termPrev && cardPrev && (!termS || !cardS);

`ifdef ISO_SNIFF_ERRSIG_EN
    logic parLat;
    logic errPending;
`else
    assign errSig = 1'b0;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state        <= ST_IDLE;
            etuCnt       <= '0;
            etuLim       <= '0;
            bitCnt       <= '0;
            shiftReg     <= '0;
            dirLat       <= DIR_TERM;
            ambLat       <= 1'b0;
            termPrev     <= 1'b1;
            cardPrev     <= 1'b1;
            dataOut      <= '0;
            dirOut       <= 1'b0;
            dirAmbiguous <= 1'b0;
            parityError  <= 1'b0;
            dataValid    <= 1'b0;
            busy         <= 1'b0;
`ifdef ISO_SNIFF_ERRSIG_EN
            parLat       <= 1'b0;
            errPending   <= 1'b0;
            errSig       <= 1'b0;
`endif
        end else begin
            dataValid <= 1'b0;
            termPrev  <= termS;
            cardPrev  <= cardS;
            if (!enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
`ifdef ISO_SNIFF_ERRSIG_EN
                errPending <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (startEdge) begin
                            dirLat <= termS ? DIR_CARD : DIR_TERM;
                            ambLat <= !termS && !cardS;
                            etuCnt <= '0;
                            etuLim <= clampedEtu;
                            bitCnt <= '0;
                            busy   <= 1'b1;
                            state  <= ST_START;
                        end
                    end
                    ST_START: begin
                        etuCnt <= etuNext;
                        if (sampleHit) begin
                            if (line) begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        etuCnt <= etuNext;
                        if (sampleHit) begin
                            shiftReg <= {line, shiftReg[7:1]};
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        etuCnt <= etuNext;
                        if (sampleHit) begin
                            state <= ST_GUARD;
`ifdef ISO_SNIFF_ERRSIG_EN
                            parLat     <= ^{shiftReg, line};
                            errPending <= 1'b1;
`else
                            etuCnt       <= '0;
                            dataOut      <= shiftReg;
                            dirOut       <= dirLat;
                            dirAmbiguous <= ambLat;
                            parityError  <= ^{shiftReg, line};
                            dataValid    <= 1'b1;
`endif
                        end
                    end
                    ST_GUARD: begin
`ifdef ISO_SNIFF_ERRSIG_EN
                        if (errPending) begin
                            etuCnt <= etuNext;
                            if (sampleHit) begin
                                etuCnt       <= '0;
                                errPending   <= 1'b0;
                                errSig       <= !line;
                                dataOut      <= shiftReg;
                                dirOut       <= dirLat;
                                dirAmbiguous <= ambLat;
                                parityError  <= parLat;
                                dataValid    <= 1'b1;
                            end
                        end else
`endif
                        // Any low restarts the one-ETU idle qualification, so no start is seen here.
                        if (!termS || !cardS) begin
                            etuCnt <= '0;
                        end else if (etuWrap) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            etuCnt <= etuNext;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
